// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR command path: arbitration states, default
// debounce length and the debounce counter width derivation.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND_S = 2'd1,
        PEND_R = 2'd2
    } sr_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

    // The counter must hold values up to DEBOUNCE_CYCLES.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sr_cmd_pulse_gen_sync_debounce.sv
// Two-flop synchronizer plus level debouncer for one raw request line;
// flags the cycle in which the accepted level is about to rise.
module sync_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_evt
);

    localparam int unsigned    CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_done;

    assign w_diff = (r_sync2 != r_db);
    assign w_done = w_diff && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // Any cycle agreeing with the accepted level restarts qualification.
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level    = r_db;
    assign rise_evt = w_done && r_sync2;

endmodule

// File: rtl/sr_cmd_pulse_gen.sv
// Command stage for an SR flip-flop: debounced set/reset requests become
// single-cycle S/R pulses, arbitrated so S and R are never high together.
module sr_cmd_pulse_gen
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          PRIORITY_SET    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req_raw,
    input  logic rst_req_raw,
    output logic S,
    output logic R,
    output logic pend,
    output logic merge
);

    logic w_rise_s, w_rise_r;
    logic w_lvl_s,  w_lvl_r;
    logic w_evt_s,  w_evt_r;

    sr_state_e r_state;

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (set_req_raw),
        .level    (w_lvl_s),
        .rise_evt (w_rise_s)
    );

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw      (rst_req_raw),
        .level    (w_lvl_r),
        .rise_evt (w_rise_r)
    );

    // A rise is only meaningful while the accepted level is still low.
    assign w_evt_s = w_rise_s && !w_lvl_s;
    assign w_evt_r = w_rise_r && !w_lvl_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            S       <= 1'b0;
            R       <= 1'b0;
            pend    <= 1'b0;
            merge   <= 1'b0;
        end else begin
            S     <= 1'b0;
            R     <= 1'b0;
            pend  <= 1'b0;
            merge <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_evt_s && w_evt_r) begin
                        pend <= 1'b1;
                        if (PRIORITY_SET) begin
                            S       <= 1'b1;
                            r_state <= PEND_R;
                        end else begin
                            R       <= 1'b1;
                            r_state <= PEND_S;
                        end
                    end else if (w_evt_s) begin
                        S <= 1'b1;
                    end else if (w_evt_r) begin
                        R <= 1'b1;
                    end
                end
                PEND_S: begin
                    S     <= 1'b1;
                    merge <= w_evt_s;
                    if (w_evt_r) begin
                        pend    <= 1'b1;
                        r_state <= PEND_R;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                PEND_R: begin
                    R     <= 1'b1;
                    merge <= w_evt_r;
                    if (w_evt_s) begin
                        pend    <= 1'b1;
                        r_state <= PEND_S;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sr_cmd_pulse_gen.md
Name: sr_cmd_pulse_gen

Overview:
Upstream command stage for the SR flip-flop. It takes two raw, asynchronous set/reset request lines (buttons, external strobes) and synchronizes and debounces each one. It converts each qualified rising edge into a single-cycle S or R pulse. It arbitrates so that S and R are never asserted together, which guarantees the downstream flip-flop never sees the invalid S=R=1 input.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clk cycles a synchronized level must stay stable before it is accepted; legal range >= 1.
PRIORITY_SET, 1, 1 = set wins a same-cycle conflict; 0 = reset wins.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; do not override).

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
set_req_raw  input  1  raw asynchronous set request, active-high level.
rst_req_raw  input  1  raw asynchronous reset request, active-high level.
S  output  1  registered one-cycle set pulse to the SR flip-flop.
R  output  1  registered one-cycle reset pulse to the SR flip-flop.
pend  output  1  high while a deferred request is scheduled for the next cycle.
merge  output  1  one-cycle pulse: a new event was absorbed by an identical pending or issuing one.

Behaviour:
- Reset (rst_n=0, async): S, R, pend and merge are 0. Sync flops, debounced levels, counters and the FSM are cleared; state is IDLE. Any pending request is discarded.
- Per channel:
  - 2-flop synchronizer (sync1 to sync2).
  - Debounced level db, reset 0.
  - Counter cnt counts edges where sync2 != db. cnt clears to 0 on any edge where sync2 == db, so glitches restart qualification.
  - When sync2 != db and cnt == DEBOUNCE_CYCLES-1, db <= sync2 and cnt <= 0 on that edge.
  - An event (evt) is asserted for exactly the cycle in which db is being updated 0 to 1.
  - A 1 to 0 update produces no output. The level must debounce low before another event is possible.
- Latency: raw rises and is stable before edge k → db and S/R go high at edge k+DEBOUNCE_CYCLES+1 and stay high for exactly one cycle.
- FSM states: IDLE, PEND_S, PEND_R. Outputs are registered and computed from next-state logic on each edge:
  - IDLE:
    - evt_s only: S=1.
    - evt_r only: R=1.
    - Both: the priority side pulses now; the other goes to PEND_x with pend=1.
  - PEND_S: S=1 this cycle (the deferred pulse). Then:
    - new evt_s: merged, merge=1.
    - new evt_r: goes to PEND_R, pend=1.
    - otherwise: goes to IDLE.
  - PEND_R: symmetric to PEND_S.
- Invariants:
  - S & R == 0 on every cycle.
  - At most one request is deferred at any time.
  - pend is high exactly in the cycle before the deferred pulse.
- Reset mid-qualification or mid-pending: nothing is emitted. If a raw line is held high across rst_n release at edge m, its pulse appears at edge m+DEBOUNCE_CYCLES+2, one edge later than the normal latency because the synchronizer also restarts.

Decomposition:
- Shared package / include sr_ctrl_pkg holds:
  - FSM state encodings: IDLE=2'd0, PEND_S=2'd1, PEND_R=2'd2.
  - Default DEBOUNCE_CYCLES.
  - CNT_W derivation function.
- One sub-module, sync_debounce:
  - Parameters: DEBOUNCE_CYCLES.
  - Ports: clk, rst_n, raw, level, rise_evt.
  - Instantiated twice, once per channel.
- The top level contains only the arbitration FSM and the output registers.

Test Plan:
1. rst_n=0 with both raw lines high → S=R=pend=merge=0 throughout reset, checked asynchronously before any clk edge.
2. DEBOUNCE_CYCLES=4: set_req_raw rises before edge 0 and is held → S=1 only between edges 5 and 6; R, pend and merge stay 0; no second pulse while the line is held.
3. set_req_raw high for 3 cycles, then low → no S pulse. Then high for 4+ cycles → exactly one S pulse at the computed edge.
4. PRIORITY_SET=1: both raw lines rise before edge 0 → edge 5: S=1, pend=1; edge 6: R=1, pend=0; S and R never coincide. Repeat with PRIORITY_SET=0 → R at edge 5, S at edge 6.
5. Force a simultaneous evt_s and evt_r while in PEND_S (stagger the inputs so the second set event lands on the pending cycle) → S=1 that cycle, merge=1, pend=1; R=1 on the next cycle.
6. Assert rst_n low after edge 3 of a set qualification → no S pulse. Release rst_n at edge m with set_req_raw still high → S=1 at edge m+6.
